// File: rtl/instr_l1_refill_if.sv
// Bus bundle between the refill engine, the fetch stage, the L1 and main memory.
// The master modport is the refill engine's view; slave is the surrounding system.
interface instr_l1_refill_if #(
  parameter int unsigned ADDR_SIZE = 14,
  parameter int unsigned WORD_SIZE = 32
);
  // Fetch stage
  logic                 cpu_req;
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_instr;
  logic                 cpu_ready;
  // Instruction L1
  logic [ADDR_SIZE-1:0] cache_addr;
  logic                 cache_we;
  logic [WORD_SIZE-1:0] cache_data;
  logic [WORD_SIZE-1:0] cache_dout;
  logic                 cache_hit;
  // Main memory
  logic                 mem_req;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_rvalid;

  modport master (
    input  cpu_req, cpu_addr, cache_dout, cache_hit, mem_rdata, mem_rvalid,
    output cpu_instr, cpu_ready, cache_addr, cache_we, cache_data, mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, cache_dout, cache_hit, mem_rdata, mem_rvalid,
    input  cpu_instr, cpu_ready, cache_addr, cache_we, cache_data, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_l1_refill.sv
// Instruction L1 miss handler: passes fetches through to the cache on hits and, on a
// miss, streams the aligned line from main memory into the cache word 0..7, word 7 last
// so the cache's LRU flip happens only once the whole line is present.
module instr_l1_refill #(
  parameter int unsigned ADDR_SIZE      = 14,
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter int unsigned OFFSET_BITS    = $clog2(WORDS_PER_LINE)
) (
  input  logic                clk,
  input  logic                reset,
  instr_l1_refill_if.master   bus,
  output logic                busy,
  output logic [15:0]         miss_count
);

  localparam int unsigned LineBits = ADDR_SIZE - OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] LastWord = OFFSET_BITS'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWrite, StDone} state_t;

  state_t                 state;
  logic [LineBits-1:0]    base_line;
  logic [OFFSET_BITS-1:0] cnt;
  logic [WORD_SIZE-1:0]   wdata;
  logic [15:0]            miss_q;
  logic [ADDR_SIZE-1:0]   line_addr;
  logic                   miss;

  // base is line-aligned, so concatenation can never carry into the index/tag bits
  assign line_addr  = {base_line, cnt};
  assign miss       = bus.cpu_req & ~bus.cache_hit;
  assign busy       = (state != StIdle);
  assign miss_count = miss_q;

  // Refill sequencer: latch the line on a miss, then alternate REQ/WRITE per word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      base_line <= '0;
      cnt       <= '0;
      wdata     <= '0;
      miss_q    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (miss) begin
            base_line <= bus.cpu_addr[ADDR_SIZE-1:OFFSET_BITS];
            cnt       <= '0;
            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            state     <= StReq;
          end
        end
        StReq: begin
          if (bus.mem_rvalid) begin
            wdata <= bus.mem_rdata;
            state <= StWrite;
          end
        end
        StWrite: begin
          if (cnt == LastWord) begin
            state <= StDone;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= StReq;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Output decode; IDLE pass-through is gated by reset so every output reads 0 in reset
  always_comb begin
    bus.cpu_instr  = reset ? '0 : bus.cache_dout;
    bus.cpu_ready  = 1'b0;
    bus.cache_addr = '0;
    bus.cache_we   = 1'b0;
    bus.cache_data = '0;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = '0;
    unique case (state)
      StIdle: begin
        if (!reset) begin
          bus.cache_addr = bus.cpu_addr;
          bus.cpu_ready  = bus.cpu_req & bus.cache_hit;
        end
      end
      StReq: begin
        bus.mem_req    = 1'b1;
        bus.mem_addr   = line_addr;
        bus.cache_addr = line_addr;
      end
      StWrite: begin
        bus.cache_we   = 1'b1;
        bus.cache_addr = line_addr;
        bus.cache_data = wdata;
      end
      StDone: begin
        bus.cache_addr = bus.cpu_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_l1_refill.sv
// Bench for instr_l1_refill: behavioural 2-way L1 and latency-configurable memory around
// the DUT, with an expected-write scoreboard checked whenever the DUT writes the cache.
module tb_instr_l1_refill;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic [15:0] miss_count;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;

  instr_l1_refill_if #(.ADDR_SIZE(14), .WORD_SIZE(32)) bus ();

  instr_l1_refill dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference data ----------------
  function automatic logic [31:0] mdata(logic [13:0] a);
    return {18'h0, a} ^ 32'hA5A50000;
  endfunction

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_line(logic [13:0] a);
    logic [13:0] base;
    base = a & 14'h3FF8;
    for (int i = 0; i < 8; i++) begin
      wr_t e;
      e.addr = base + 14'(i);
      e.data = mdata(base + 14'(i));
      exp_q.push_back(e);
    end
  endtask

  // ---------------- 2-way L1 model: 32 sets, 8-word lines ----------------
  logic [31:0] cmem [2][32][8];
  logic [5:0]  ctag [2][32];
  logic        cval [2][32];
  logic        clru [32];

  logic [4:0] c_idx;
  logic [5:0] c_tag;
  logic [2:0] c_off;
  logic       hit0, hit1;

  always_comb begin
    c_idx = bus.cache_addr[7:3];
    c_tag = bus.cache_addr[13:8];
    c_off = bus.cache_addr[2:0];
    hit0  = cval[0][c_idx] && (ctag[0][c_idx] == c_tag);
    hit1  = cval[1][c_idx] && (ctag[1][c_idx] == c_tag);
    bus.cache_hit  = hit0 | hit1;
    bus.cache_dout = hit0 ? cmem[0][c_idx][c_off] : (hit1 ? cmem[1][c_idx][c_off] : 32'h0);
  end

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 32; s++) begin
        cval[0][s] <= 1'b0;
        cval[1][s] <= 1'b0;
        clru[s]    <= 1'b0;
      end
    end else if (bus.cache_we) begin
      cmem[clru[c_idx]][c_idx][c_off] <= bus.cache_data;
      if (c_off == 3'd7) begin
        ctag[clru[c_idx]][c_idx] <= c_tag;
        cval[clru[c_idx]][c_idx] <= 1'b1;
        clru[c_idx]              <= ~clru[c_idx];
      end
    end
  end

  // ---------------- memory model ----------------
  logic zero_lat = 1'b0;
  logic rv_q;
  int   wait_cnt;

  assign bus.mem_rdata  = mdata(bus.mem_addr);
  assign bus.mem_rvalid = zero_lat ? bus.mem_req : rv_q;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_q     <= 1'b0;
      wait_cnt <= 0;
    end else begin
      rv_q <= 1'b0;
      if (!zero_lat && bus.mem_req && !rv_q) begin
        if (wait_cnt == 1) begin
          rv_q     <= 1'b1;
          wait_cnt <= 0;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_req && bus.mem_rvalid) begin
        if (exp_q.size() == 0) check("mem_req_unexpected", 32'(bus.mem_req), 32'h0);
        else check("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
      end
      if (bus.cache_we) begin
        wr_cnt++;
        check("busy_during_write", 32'(busy), 32'h1);
        if (exp_q.size() == 0) begin
          check("write_unexpected", 32'(bus.cache_we), 32'h0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", 32'(bus.cache_addr), 32'(e.addr));
          check("write_data", bus.cache_data, e.data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_ready(string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cpu_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.cpu_ready), 32'h1);
  endtask

  task automatic wait_writes(int target);
    int n;
    n = 0;
    while (wr_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_writes", 32'(wr_cnt >= target), 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int w0;
    reset        = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    #12;
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_miss_count", 32'(miss_count), 32'h0);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_cache_we", 32'(bus.cache_we), 32'h0);
    check("rst_cache_addr", 32'(bus.cache_addr), 32'h0);
    do_reset();

    // 1: cold miss with 2-cycle memory
    @(posedge clk); #1;
    push_line(14'h0123);
    bus.cpu_addr = 14'h0123;
    bus.cpu_req  = 1'b1;
    wait_ready("t1_ready");
    check("t1_instr", bus.cpu_instr, 32'hA5A50123);
    check("t1_miss_count", 32'(miss_count), 32'h1);
    check("t1_queue_empty", 32'(exp_q.size()), 32'h0);

    // 2: hit after fill, same-cycle ready
    @(posedge clk); #1;
    bus.cpu_addr = 14'h0127;
    #1;
    check("t2_ready", 32'(bus.cpu_ready), 32'h1);
    check("t2_instr", bus.cpu_instr, 32'hA5A50127);
    check("t2_mem_req", 32'(bus.mem_req), 32'h0);
    @(negedge clk);
    check("t2_busy", 32'(busy), 32'h0);
    check("t2_miss_count", 32'(miss_count), 32'h1);

    // 3: zero-latency memory, top line
    do_reset();
    zero_lat = 1'b1;
    @(posedge clk); #1;
    push_line(14'h3FFF);
    bus.cpu_addr = 14'h3FFF;
    bus.cpu_req  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t3_busy_cycles", 32'(n), 32'd17);
    check("t3_ready", 32'(bus.cpu_ready), 32'h1);
    check("t3_instr", bus.cpu_instr, 32'hA5A53FFF);
    check("t3_queue_empty", 32'(exp_q.size()), 32'h0);
    zero_lat = 1'b0;

    // 4: address change and request drop mid-refill
    do_reset();
    w0 = wr_cnt;
    @(posedge clk); #1;
    push_line(14'h0040);
    bus.cpu_addr = 14'h0040;
    bus.cpu_req  = 1'b1;
    wait_writes(w0 + 3);
    @(posedge clk); #1;
    bus.cpu_addr = 14'h0200;
    bus.cpu_req  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t4_still_busy", 32'(busy), 32'h1);
    push_line(14'h0200);
    bus.cpu_req = 1'b1;
    wait_ready("t4_ready");
    check("t4_instr", bus.cpu_instr, 32'hA5A50200);
    check("t4_miss_count", 32'(miss_count), 32'h2);
    check("t4_writes", 32'(wr_cnt - w0), 32'd16);
    check("t4_queue_empty", 32'(exp_q.size()), 32'h0);

    // 5: asynchronous reset while requesting word 5
    do_reset();
    w0 = wr_cnt;
    @(posedge clk); #1;
    push_line(14'h0300);
    bus.cpu_addr = 14'h0300;
    bus.cpu_req  = 1'b1;
    wait_writes(w0 + 5);
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_req", 32'(bus.mem_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t5_mem_req", 32'(bus.mem_req), 32'h0);
    check("t5_cache_we", 32'(bus.cache_we), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_cpu_ready", 32'(bus.cpu_ready), 32'h0);
    check("t5_miss_count", 32'(miss_count), 32'h0);
    exp_q.delete();
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("t5_no_writes", 32'(wr_cnt - w0), 32'h0);

    // 6: saturation, then two tags sharing one set
    @(posedge clk); #1;
    force dut.miss_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.miss_q;
    @(posedge clk); #1;
    check("t6_preload", 32'(miss_count), 32'hFFFE);
    push_line(14'h0008);
    bus.cpu_addr = 14'h0008;
    bus.cpu_req  = 1'b1;
    wait_ready("t6_ready_a");
    check("t6_miss_sat_a", 32'(miss_count), 32'hFFFF);
    @(posedge clk); #1;
    push_line(14'h0108);
    bus.cpu_addr = 14'h0108;
    wait_ready("t6_ready_b");
    check("t6_miss_sat_b", 32'(miss_count), 32'hFFFF);
    @(posedge clk); #1;
    bus.cpu_addr = 14'h000A;
    #1;
    check("t6_hit_a", 32'(bus.cpu_ready), 32'h1);
    check("t6_instr_a", bus.cpu_instr, 32'hA5A5000A);
    @(posedge clk); #1;
    bus.cpu_addr = 14'h010F;
    #1;
    check("t6_hit_b", 32'(bus.cpu_ready), 32'h1);
    check("t6_instr_b", bus.cpu_instr, 32'hA5A5010F);
    check("t6_queue_empty", 32'(exp_q.size()), 32'h0);
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_l1_refill.md
Name: instr_l1_refill

Overview:
- Miss handler sitting directly upstream of the 2-way instruction L1 (14-bit word address, 8-word lines, write-on-negedge, async-read hit/dout).
- Arbitrates the cache's addr/we/data inputs between the fetch stage and line refills.
- On a fetch miss, reads the whole aligned 8-word line from main memory one word at a time and writes it into the cache in order word 0..7.
- The cache flips its LRU bit on the word-7 write, so word 7 is always written last.

Parameters:
ADDR_SIZE, 14, word-address width (matches cache)
WORD_SIZE, 32, data word width
WORDS_PER_LINE, 8, words per cache line; power of two
OFFSET_BITS, $clog2(WORDS_PER_LINE), word-offset field width

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
cpu_req  in  1  fetch stage requests instruction at cpu_addr
cpu_addr  in  ADDR_SIZE  fetch word address
cpu_instr  out  WORD_SIZE  instruction to fetch stage (= cache_dout)
cpu_ready  out  1  cpu_instr valid this cycle
cache_addr  out  ADDR_SIZE  drives cache addr
cache_we  out  1  drives cache we
cache_data  out  WORD_SIZE  drives cache data
cache_dout  in  WORD_SIZE  cache read data
cache_hit  in  1  cache hit flag
mem_req  out  1  word read request to main memory
mem_addr  out  ADDR_SIZE  word address of the request
mem_rdata  in  WORD_SIZE  memory read data
mem_rvalid  in  1  one-cycle pulse; mem_rdata valid for the outstanding request
busy  out  1  refill in progress (state != IDLE)
miss_count  out  16  number of refills started; saturates at 0xFFFF

Behaviour:
- Reset values: all outputs 0, state IDLE, cnt 0, base 0, miss_count 0.
- Reset is asynchronous; asserting it mid-refill aborts immediately with no further cache_we. A partial line may already be in the cache; the cache's own reset on the shared reset line clears its valid bits.

States and transitions:
- IDLE:
  - cache_addr = cpu_addr, cache_we = 0.
  - cpu_ready = cpu_req & cache_hit (zero added latency on a hit).
  - If cpu_req & !cache_hit: base <= {cpu_addr[ADDR_SIZE-1:OFFSET_BITS], 0}, cnt <= 0, miss_count += 1 (saturating), go to REQ.
- REQ:
  - mem_req = 1, mem_addr = base + cnt, cache_addr = base + cnt.
  - Held until mem_rvalid. On mem_rvalid: wdata <= mem_rdata, go to WRITE.
  - mem_rvalid outside REQ is ignored.
- WRITE (exactly one cycle):
  - cache_we = 1, cache_addr = base + cnt, cache_data = wdata, mem_req = 0.
  - The cache captures the write on the negedge inside this cycle.
  - If cnt == WORDS_PER_LINE-1, go to DONE; else cnt <= cnt + 1 and go to REQ.
- DONE (one cycle):
  - cache_addr = cpu_addr, cpu_ready = 0.
  - Always go to IDLE, where the re-lookup hits.
- cpu_ready is 0 in every state except IDLE.

Boundary rules:
- cnt is an OFFSET_BITS counter. base + cnt never carries into tag or index bits because base is line-aligned. The top line 0x3FF8..0x3FFF must not wrap to 0.
- cpu_req dropping or cpu_addr changing mid-refill: ignored; the refill completes for the latched base.
- Minimum refill time is 8 × (memory latency + 1 WRITE cycle) + DONE + the IDLE re-lookup.
- Zero-latency memory (mem_rvalid in the same cycle mem_req rises) is legal: REQ lasts 1 cycle, giving 8 × 2 + 1 = 17 cycles from miss-detect to DONE exit.
- Only one memory request is outstanding at a time. mem_addr is stable while mem_req = 1.
- cpu_req & cache_hit with no prior miss does not touch miss_count.

Test Plan:
1. Cold miss, fixed latency:
   - Stimulus: reset, then cpu_req = 1, cpu_addr = 0x0123; memory returns data = addr ^ 0xA5A50000 with 2-cycle latency.
   - Required: mem_addr sequence 0x0120..0x0127; 8 cache_we pulses in address order; busy high throughout; then cpu_ready = 1 with cpu_instr = 0xA5A50123; miss_count = 1.
2. Hit after fill:
   - Stimulus: following case 1, cpu_addr = 0x0127.
   - Required: cpu_ready in the same cycle, cpu_instr = 0xA5A50127, no mem_req, miss_count stays 1.
3. Zero-latency memory:
   - Stimulus: mem_rvalid tied to mem_req; miss at 0x3FFF.
   - Required: mem_addr 0x3FF8..0x3FFF with no wrap; DONE exit exactly 17 cycles after miss detect; cpu_instr = the word for 0x3FFF.
4. Address change mid-refill:
   - Stimulus: miss at 0x0040; after the 3rd word, switch cpu_addr to 0x0200 and drop cpu_req for 4 cycles.
   - Required: words 0x0040..0x0047 written; then, back in IDLE, a miss at 0x0200 starts a new refill; miss_count = 2.
5. Async reset mid-refill:
   - Stimulus: assert reset between posedges while in REQ for word 5.
   - Required: mem_req, cache_we, busy, cpu_ready all 0 before the next posedge; miss_count = 0; no further writes.
6. Saturation and LRU interaction:
   - Stimulus: force 0xFFFF misses (or preload via force).
   - Required: miss_count holds at 0xFFFF.
   - Stimulus: two refills to different tags of the same index (0x0008, 0x0108).
   - Required: both lines hit afterwards.
